// File: rtl/stopwatch_timebase.sv
// Stopwatch timebase: prescales clk to a 10 ms tick and accumulates elapsed time
// as packed BCD MM:SS.hh, with wrap or saturate behaviour at 59:59.99.
module stopwatch_timebase #(
  parameter int unsigned TICK_DIV = 500000,
  parameter bit          WRAP     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        count,
  output logic [23:0] time_bcd,
  output logic        tick,
  output logic        ovf
);

  localparam int unsigned PresW = $clog2(TICK_DIV);
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
  localparam logic [23:0] TimeMax = 24'h595999;

  logic [PresW-1:0] presc_q, presc_d;
  logic [23:0]      time_q, time_d, time_inc;
  logic             tick_q, tick_d;
  logic             ovf_q, ovf_d;

  logic             carry;
  logic [3:0]       dig;
  logic [3:0]       lim;

  // Ripple a +0.01 s increment through all six digits in one cycle.
  // Digit 3 (seconds tens) and digit 5 (minutes tens) roll over at 5.
  always_comb begin
    time_inc = time_q;
    carry    = 1'b1;
    dig      = 4'd0;
    lim      = 4'd9;
    for (int i = 0; i < 6; i++) begin
      dig = time_q[4*i +: 4];
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (dig >= lim) begin
          time_inc[4*i +: 4] = 4'd0;
        end else begin
          time_inc[4*i +: 4] = dig + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    tick_d  = 1'b0;
    // Wrap mode pulses ovf; saturate mode holds it until clr/reset.
    ovf_d   = WRAP ? 1'b0 : ovf_q;

    if (clr) begin
      presc_d = '0;
      time_d  = '0;
      ovf_d   = 1'b0;
    end else if (count) begin
      if (presc_q == PresMax) begin
        presc_d = '0;
        if (time_q == TimeMax) begin
          ovf_d = 1'b1;
          if (WRAP) begin
            time_d = '0;
            tick_d = 1'b1;
          end
        end else begin
          time_d = time_inc;
          tick_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + PresW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      time_q  <= '0;
      tick_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
      ovf_q   <= ovf_d;
    end
  end

  assign time_bcd = time_q;
  assign tick     = tick_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Bench for stopwatch_timebase: three instances (TICK_DIV=4 wrap, 2 wrap, 2 saturate)
// checked every cycle against an integer centisecond model plus directed checkpoints.
module tb_stopwatch_timebase;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr [3];
  logic        cnt [3];
  logic [23:0] tb_o [3];
  logic        tk [3];
  logic        ov [3];

  int checks = 0;
  int errors = 0;

  // Model state: prescaler phase and elapsed centiseconds per instance.
  int phase [3];
  int cs    [3];
  bit mtick [3];
  bit movf  [3];

  stopwatch_timebase #(.TICK_DIV(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clr(clr[0]), .count(cnt[0]),
    .time_bcd(tb_o[0]), .tick(tk[0]), .ovf(ov[0])
  );

  stopwatch_timebase #(.TICK_DIV(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .clr(clr[1]), .count(cnt[1]),
    .time_bcd(tb_o[1]), .tick(tk[1]), .ovf(ov[1])
  );

  stopwatch_timebase #(.TICK_DIV(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .clr(clr[2]), .count(cnt[2]),
    .time_bcd(tb_o[2]), .tick(tk[2]), .ovf(ov[2])
  );

  always #5 clk = ~clk;

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic bit wrap_of(int i);
    return (i != 2);
  endfunction

  function automatic logic [23:0] to_bcd(int c);
    int m, s, h;
    m = c / 6000;
    s = (c / 100) % 60;
    h = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic logic legal(logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < 6; d++) begin
      if (t[4*d +: 4] > ((d == 3 || d == 5) ? 4'd5 : 4'd9)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int i);
    if (reset || clr[i]) begin
      phase[i] = 0;
      cs[i]    = 0;
      mtick[i] = 1'b0;
      movf[i]  = 1'b0;
    end else begin
      mtick[i] = 1'b0;
      if (wrap_of(i)) movf[i] = 1'b0;
      if (cnt[i]) begin
        if (phase[i] == div_of(i) - 1) begin
          phase[i] = 0;
          if (cs[i] == 359999) begin
            movf[i] = 1'b1;
            if (wrap_of(i)) begin
              cs[i]    = 0;
              mtick[i] = 1'b1;
            end
          end else begin
            cs[i]    = cs[i] + 1;
            mtick[i] = 1'b1;
          end
        end else begin
          phase[i] = phase[i] + 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("time%0d", i), tb_o[i], to_bcd(cs[i]));
      check($sformatf("tick%0d", i), {23'd0, tk[i]}, {23'd0, mtick[i]});
      check($sformatf("ovf%0d", i), {23'd0, ov[i]}, {23'd0, movf[i]});
      check($sformatf("digits%0d", i), {23'd0, legal(tb_o[i])}, 24'd1);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clr[i]   = 1'b0;
      cnt[i]   = 1'b0;
      phase[i] = 0;
      cs[i]    = 0;
      mtick[i] = 1'b0;
      movf[i]  = 1'b0;
    end

    // Reset
    cycles(2);
    check("reset_time", tb_o[0], 24'h000000);
    check("reset_flags", {22'd0, tk[0], ov[0]}, 24'd0);
    reset = 1'b0;

    // Run 40 edges then clear; first tick 4 edges after clr drops
    cnt[0] = 1'b1;
    cycles(40);
    check("run40", tb_o[0], 24'h000010);
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    check("clr_time", tb_o[0], 24'h000000);
    cycles(3);
    check("no_tick_e3", {23'd0, tk[0]}, 24'd0);
    cycle();
    check("tick_e4", {23'd0, tk[0]}, 24'd1);
    check("time_e4", tb_o[0], 24'h000001);
    cycles(4);
    check("tick_e8", {23'd0, tk[0]}, 24'd1);
    cycles(4);
    check("tick_e12", {23'd0, tk[0]}, 24'd1);
    check("time_e12", tb_o[0], 24'h000003);

    // Pause/resume keeps the partial tick
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    cycles(2);
    cnt[0] = 1'b0;
    cycles(10);
    check("paused", tb_o[0], 24'h000000);
    cnt[0] = 1'b1;
    cycle();
    check("resume_e1", {23'd0, tk[0]}, 24'd0);
    cycle();
    check("resume_e2", {23'd0, tk[0]}, 24'd1);

    // Random count/clr mix, including clr and count together
    for (int k = 0; k < 400; k++) begin
      cnt[0] = ($urandom_range(0, 3) != 0);
      clr[0] = ($urandom_range(0, 24) == 0);
      cycle();
    end
    clr[0] = 1'b0;
    cnt[0] = 1'b0;

    // Carry chain
    clr[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    cnt[1] = 1'b1;
    cycles(200);
    check("carry_100", tb_o[1], 24'h000100);
    cycles(11800);
    check("carry_6000", tb_o[1], 24'h010000);

    // Wrap: preload near terminal while holding
    clr[1] = 1'b1;
    cnt[1] = 1'b0;
    cycle();
    clr[1] = 1'b0;
    force dut_w.time_q = 24'h595990;
    cs[1] = 359990;
    cycle();
    release dut_w.time_q;
    cnt[1] = 1'b1;
    cycles(18);
    check("wrap_pre", tb_o[1], 24'h595999);
    cycles(2);
    check("wrap_time", tb_o[1], 24'h000000);
    check("wrap_ovf", {23'd0, ov[1]}, 24'd1);
    cycle();
    check("wrap_ovf_drop", {23'd0, ov[1]}, 24'd0);
    cnt[1] = 1'b0;

    // Saturate
    clr[2] = 1'b1;
    cycle();
    clr[2] = 1'b0;
    force dut_s.time_q = 24'h595995;
    cs[2] = 359995;
    cycle();
    release dut_s.time_q;
    cnt[2] = 1'b1;
    cycles(8);
    check("sat_reach", tb_o[2], 24'h595999);
    check("sat_no_ovf_yet", {23'd0, ov[2]}, 24'd0);
    cycles(40);
    check("sat_hold", tb_o[2], 24'h595999);
    check("sat_ovf", {23'd0, ov[2]}, 24'd1);
    check("sat_tick", {23'd0, tk[2]}, 24'd0);
    clr[2] = 1'b1;
    cycle();
    check("sat_clr_time", tb_o[2], 24'h000000);
    check("sat_clr_ovf", {23'd0, ov[2]}, 24'd0);
    clr[2] = 1'b0;
    cycles(4);
    check("sat_restart", tb_o[2], 24'h000002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
